// File: rtl/execute_hazard_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// execute_hazard_ctrl_pkg
// Shared definitions for the execute-stage hazard controller:
//   - RV32 base opcode constants (OP_*)
//   - hz_state_t : sequencing FSM states (RUN, LDUSE, MDWAIT)
//   - uses_rs1() / uses_rs2() : which opcodes actually read rs1 / rs2
// -----------------------------------------------------------------------------
package execute_hazard_ctrl_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        LDUSE  = 2'd1,
        MDWAIT = 2'd2
    } hz_state_t;

    // rs1 is a real source operand only for these formats; other formats
    // reuse bits [19:15] as immediate bits and must not create a hazard.
    function automatic logic uses_rs1(input logic [6:0] opcode);
        logic used;
        case (opcode)
            OP_OP, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_JALR: used = 1'b1;
            default:                                              used = 1'b0;
        endcase
        return used;
    endfunction

    // rs2 is read only by R-type, stores and branches.
    function automatic logic uses_rs2(input logic [6:0] opcode);
        logic used;
        case (opcode)
            OP_OP, OP_STORE, OP_BRANCH: used = 1'b1;
            default:                    used = 1'b0;
        endcase
        return used;
    endfunction

endpackage

// File: rtl/execute_hazard_ctrl_if.sv
// -----------------------------------------------------------------------------
// execute_hazard_ctrl_if
// Bundle between the pipeline (master) and the hazard controller (slave).
//   pipeline -> ctrl : id_inst, ex_load, ex_dst, ex_br_taken, ex_md, md_done
//   ctrl -> pipeline : if_stall, id_stall, if_flush, ex_bubble, ex_hold,
//                      md_go, md_err, stall_cnt[CNT_W-1:0]
// -----------------------------------------------------------------------------
interface execute_hazard_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [31:0]      id_inst;
    logic             ex_load;
    logic [4:0]       ex_dst;
    logic             ex_br_taken;
    logic             ex_md;
    logic             md_done;
    logic             if_stall;
    logic             id_stall;
    logic             if_flush;
    logic             ex_bubble;
    logic             ex_hold;
    logic             md_go;
    logic             md_err;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output id_inst, ex_load, ex_dst, ex_br_taken, ex_md, md_done,
        input  if_stall, id_stall, if_flush, ex_bubble, ex_hold, md_go, md_err, stall_cnt
    );

    modport slave (
        input  id_inst, ex_load, ex_dst, ex_br_taken, ex_md, md_done,
        output if_stall, id_stall, if_flush, ex_bubble, ex_hold, md_go, md_err, stall_cnt
    );
endinterface

// File: rtl/execute_hazard_ctrl_hz_detect.sv
// -----------------------------------------------------------------------------
// execute_hazard_ctrl_hz_detect
// Combinational load-use hazard term between the EX load and the ID instr.
//   opcode/rs1/rs2 : decoded fields of the ID instruction
//   ex_load/ex_dst : EX instruction is a load, and its destination
//   haz            : ID must wait for the load result
// -----------------------------------------------------------------------------
module execute_hazard_ctrl_hz_detect
    import execute_hazard_ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [4:0] rs1,
    input  logic [4:0] rs2,
    input  logic       ex_load,
    input  logic [4:0] ex_dst,
    output logic       haz
);
    // x0 is hardwired zero, so a load targeting it never produces a hazard.
    assign haz = ex_load && (ex_dst != 5'd0) &&
                 ((uses_rs1(opcode) && (rs1 == ex_dst)) ||
                  (uses_rs2(opcode) && (rs2 == ex_dst)));
endmodule

// File: rtl/execute_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// execute_hazard_ctrl
// Execute-stage sequencing: load-use bubbles, taken-branch squash and
// mul/div hold with timeout. All control outputs are Mealy (same cycle).
//   clk, rst : clock, synchronous active-high reset
//   bus      : execute_hazard_ctrl_if.slave (stage info in, controls out)
// Parameters: BUB_CYC (1..7) bubbles per load-use, MD_TMO mul/div timeout,
//             CNT_W stall counter width.
// -----------------------------------------------------------------------------
module execute_hazard_ctrl
    import execute_hazard_ctrl_pkg::*;
#(
    parameter int BUB_CYC = 1,
    parameter int MD_TMO  = 40,
    parameter int CNT_W   = 32
) (
    input  logic                clk,
    input  logic                rst,
    execute_hazard_ctrl_if.slave bus
);
    localparam int              TMO_W    = $clog2(MD_TMO) + 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MD_TMO - 1);
    localparam logic [2:0]      BUB_LOAD = 3'(BUB_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    hz_state_t        state_q, state_d;
    logic [2:0]       bub_q, bub_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic             haz_s;
    logic             if_stall_s, id_stall_s, if_flush_s, ex_bubble_s, ex_hold_s, md_go_s;

    execute_hazard_ctrl_hz_detect u_hz_detect (
        .opcode  (bus.id_inst[6:0]),
        .rs1     (bus.id_inst[19:15]),
        .rs2     (bus.id_inst[24:20]),
        .ex_load (bus.ex_load),
        .ex_dst  (bus.ex_dst),
        .haz     (haz_s)
    );

    // Next-state and Mealy control decode; controls are forced low during reset.
    always_comb begin
        state_d     = state_q;
        bub_d       = bub_q;
        tmo_d       = tmo_q;
        err_d       = err_q;
        if_stall_s  = 1'b0;
        id_stall_s  = 1'b0;
        if_flush_s  = 1'b0;
        ex_bubble_s = 1'b0;
        ex_hold_s   = 1'b0;
        md_go_s     = 1'b0;
        if (!rst) begin
            case (state_q)
                RUN: begin
                    if (bus.ex_br_taken) begin
                        // Squash wins: the ID instruction is on the wrong path anyway.
                        if_flush_s  = 1'b1;
                        ex_bubble_s = 1'b1;
                    end else if (bus.ex_md) begin
                        md_go_s    = 1'b1;
                        if_stall_s = 1'b1;
                        id_stall_s = 1'b1;
                        ex_hold_s  = 1'b1;
                        tmo_d      = '0;
                        state_d    = MDWAIT;
                    end else if (haz_s) begin
                        if_stall_s  = 1'b1;
                        id_stall_s  = 1'b1;
                        ex_bubble_s = 1'b1;
                        if (BUB_CYC > 1) begin
                            bub_d   = BUB_LOAD;
                            state_d = LDUSE;
                        end else begin
                            state_d = RUN;
                        end
                    end else begin
                        state_d = RUN;
                    end
                end
                LDUSE: begin
                    if_stall_s  = 1'b1;
                    id_stall_s  = 1'b1;
                    ex_bubble_s = 1'b1;
                    // Last bubble when the counter shows 1 (RUN cycle counted the first).
                    if (bub_q <= 3'd1) begin
                        bub_d   = 3'd0;
                        state_d = RUN;
                    end else begin
                        bub_d = bub_q - 3'd1;
                    end
                end
                MDWAIT: begin
                    // Holds drop in the release cycle so EX/MA captures the result.
                    if (bus.md_done) begin
                        state_d = RUN;
                    end else if (tmo_q == TMO_LAST) begin
                        err_d   = 1'b1;
                        state_d = RUN;
                    end else begin
                        if_stall_s = 1'b1;
                        id_stall_s = 1'b1;
                        ex_hold_s  = 1'b1;
                        tmo_d      = tmo_q + TMO_W'(1);
                    end
                end
                default: begin
                    state_d = RUN;
                end
            endcase
        end else begin
            state_d = RUN;
        end
    end

    // Saturating count of stalled fetch cycles.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (if_stall_s && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // State, counters and sticky error register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RUN;
            bub_q       <= 3'd0;
            tmo_q       <= '0;
            err_q       <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            bub_q       <= bub_d;
            tmo_q       <= tmo_d;
            err_q       <= err_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.if_stall  = if_stall_s;
    assign bus.id_stall  = id_stall_s;
    assign bus.if_flush  = if_flush_s;
    assign bus.ex_bubble = ex_bubble_s;
    assign bus.ex_hold   = ex_hold_s;
    assign bus.md_go     = md_go_s;
    assign bus.md_err    = err_q;
    assign bus.stall_cnt = stall_cnt_q;
endmodule
